prog_clock_divider: RTL and testbench

PROG_CLOCK_DIVIDER -- requirements
Module: prog_clock_divider

---
 rtl/prog_clock_divider.sv | 110 +++++++++++
 tb/tb_prog_clock_divider.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/prog_clock_divider.sv
// Multi-channel programmable clock divider with shadowed divisor reload at half-period boundaries.
// Define CLKDIV_TICK_EN to build the per-channel rising-edge tick registers; otherwise tick is tied to 0.
module prog_clock_divider #(
    parameter int unsigned NUM_CH      = 2,
    parameter int unsigned DIV_W       = 16,
    parameter int unsigned DEFAULT_DIV = 500
) (
    input  logic                      in_clk,
    input  logic                      rst,
    input  logic [NUM_CH-1:0]         en,
    input  logic [NUM_CH-1:0]         load,
    input  logic [NUM_CH*DIV_W-1:0]   div_val,
    output logic [NUM_CH-1:0]         out_clk,
    output logic [NUM_CH-1:0]         tick,
    output logic [NUM_CH-1:0]         pending
);

    logic [DIV_W-1:0]  a_q   [NUM_CH];
    logic [DIV_W-1:0]  a_d   [NUM_CH];
    logic [DIV_W-1:0]  s_q   [NUM_CH];
    logic [DIV_W-1:0]  s_d   [NUM_CH];
    logic [DIV_W-1:0]  cnt_q [NUM_CH];
    logic [DIV_W-1:0]  cnt_d [NUM_CH];
    logic [NUM_CH-1:0] out_q, out_d;
    logic [NUM_CH-1:0] pend_q, pend_d;
`ifdef CLKDIV_TICK_EN
    logic [NUM_CH-1:0] tick_q, tick_d;
`endif

    // Per-channel next state: divisor changes only land at a boundary while running.
    always_comb begin
        out_d  = out_q;
        pend_d = pend_q;
`ifdef CLKDIV_TICK_EN
        tick_d = '0;
`endif
        for (int c = 0; c < NUM_CH; c++) begin
            logic [DIV_W-1:0] div_in;
            logic [DIV_W-1:0] eff;
            logic             bnd;
            div_in   = div_val[c*DIV_W +: DIV_W];
            eff      = (a_q[c] == '0) ? DIV_W'(1) : a_q[c];
            bnd      = en[c] && (cnt_q[c] == eff - DIV_W'(1));
            cnt_d[c] = cnt_q[c];
            a_d[c]   = a_q[c];
            s_d[c]   = s_q[c];
`ifdef CLKDIV_TICK_EN
            tick_d[c] = bnd && !out_q[c];
`endif
            if (!en[c]) begin
                if (load[c]) begin
                    a_d[c]    = div_in;
                    cnt_d[c]  = '0;
                    pend_d[c] = 1'b0;
                end
            end else if (bnd) begin
                cnt_d[c] = '0;
                out_d[c] = !out_q[c];
                if (load[c]) begin
                    a_d[c]    = div_in;
                    pend_d[c] = 1'b0;
                end else if (pend_q[c]) begin
                    a_d[c]    = s_q[c];
                    pend_d[c] = 1'b0;
                end
            end else begin
                cnt_d[c] = cnt_q[c] + DIV_W'(1);
                if (load[c]) begin
                    s_d[c]    = div_in;
                    pend_d[c] = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge in_clk or posedge rst) begin
        if (rst) begin
            out_q  <= '0;
            pend_q <= '0;
`ifdef CLKDIV_TICK_EN
            tick_q <= '0;
`endif
            for (int c = 0; c < NUM_CH; c++) begin
                a_q[c]   <= DIV_W'(DEFAULT_DIV);
                s_q[c]   <= DIV_W'(DEFAULT_DIV);
                cnt_q[c] <= '0;
            end
        end else begin
            out_q  <= out_d;
            pend_q <= pend_d;
`ifdef CLKDIV_TICK_EN
            tick_q <= tick_d;
`endif
            for (int c = 0; c < NUM_CH; c++) begin
                a_q[c]   <= a_d[c];
                s_q[c]   <= s_d[c];
                cnt_q[c] <= cnt_d[c];
            end
        end
    end

    assign out_clk = out_q;
    assign pending = pend_q;
`ifdef CLKDIV_TICK_EN
    assign tick = tick_q;
`else
    assign tick = '0;
`endif

endmodule

// File: tb/tb_prog_clock_divider.sv
// Directed bench for prog_clock_divider (2 channels, DIV_W=16, DEFAULT_DIV=500); ch1 free-runs as a reference.
module tb_prog_clock_divider;

    localparam int unsigned NUM_CH = 2;
    localparam int unsigned DIV_W  = 16;

    logic                    in_clk;
    logic                    rst;
    logic [NUM_CH-1:0]       en;
    logic [NUM_CH-1:0]       load;
    logic [NUM_CH*DIV_W-1:0] div_val;
    logic [NUM_CH-1:0]       out_clk;
    logic [NUM_CH-1:0]       tick;
    logic [NUM_CH-1:0]       pending;

    int n_cmp  = 0;
    int n_fail = 0;
    int cyc    = 0;
    int tick_cnt0 = 0;
    int tick_cnt1 = 0;
    logic t_on;

    prog_clock_divider #(.NUM_CH(NUM_CH), .DIV_W(DIV_W), .DEFAULT_DIV(500)) dut (
        .in_clk  (in_clk),
        .rst     (rst),
        .en      (en),
        .load    (load),
        .div_val (div_val),
        .out_clk (out_clk),
        .tick    (tick),
        .pending (pending)
    );

    initial in_clk = 1'b0;
    always #5 in_clk = ~in_clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge in_clk);
            #1;
            cyc++;
            tick_cnt0 += int'(tick[0]);
            tick_cnt1 += int'(tick[1]);
        end
    endtask

    function automatic logic ch1_exp();
        return 1'((cyc / 500) % 2);
    endfunction

    initial begin
`ifdef CLKDIV_TICK_EN
        t_on = 1'b1;
`else
        t_on = 1'b0;
`endif
        rst = 1'b1; en = 2'b11; load = 2'b00; div_val = '0;
        #2;
        chk("reset_out", 32'(out_clk), 32'd0);
        chk("reset_pending", 32'(pending), 32'd0);
        chk("reset_tick", 32'(tick), 32'd0);
        @(posedge in_clk); #1;
        rst = 1'b0; cyc = 0; tick_cnt0 = 0; tick_cnt1 = 0;

        // Default divisor: rise at 500, fall at 1000
        step(499);
        chk("def_before_rise", 32'(out_clk), 32'd0);
        step(1);
        chk("def_rise", 32'(out_clk), 32'b11);
        chk("def_tick_pulse", 32'(tick), {30'd0, t_on, t_on});
        step(1);
        chk("def_tick_clear", 32'(tick), 32'd0);
        step(498);
        chk("def_before_fall", 32'(out_clk), 32'b11);
        step(1);
        chk("def_fall", 32'(out_clk), 32'd0);
        chk("def_tick_count", 32'(tick_cnt0), t_on ? 32'd1 : 32'd0);

        // Shadow load mid half-period, overwritten (5 then 3), applied at the boundary at 1500
        step(10);
        load = 2'b01; div_val[15:0] = 16'd5;
        step(1);
        chk("shadow_pending", 32'(pending), 32'b01);
        div_val[15:0] = 16'd3;
        step(1);
        load = 2'b00;
        step(487);
        chk("shadow_hold_pending", 32'(pending), 32'b01);
        chk("shadow_hold_out", 32'(out_clk[0]), 32'd0);
        step(1);
        chk("shadow_apply_out", 32'(out_clk[0]), 32'd1);
        chk("shadow_apply_pending", 32'(pending), 32'd0);
        chk("ch1_at_1500", 32'(out_clk[1]), 32'(ch1_exp()));
        step(2);
        chk("div3_high2", 32'(out_clk[0]), 32'd1);
        step(1);
        chk("div3_fall", 32'(out_clk[0]), 32'd0);
        step(2);
        chk("div3_low2", 32'(out_clk[0]), 32'd0);
        step(1);
        chk("div3_rise", 32'(out_clk[0]), 32'd1);
        chk("div3_tick", 32'(tick[0]), 32'(t_on));

        // Load coincident with the boundary at 1509 goes straight to A
        step(2);
        load = 2'b01; div_val[15:0] = 16'd2;
        step(1);
        load = 2'b00;
        chk("coinc_out", 32'(out_clk[0]), 32'd0);
        chk("coinc_pending", 32'(pending), 32'd0);
        step(1);
        chk("div2_low1", 32'(out_clk[0]), 32'd0);
        step(1);
        chk("div2_rise", 32'(out_clk[0]), 32'd1);
        step(1);
        chk("div2_high1", 32'(out_clk[0]), 32'd1);
        step(1);
        chk("div2_fall", 32'(out_clk[0]), 32'd0);

        // Disabled channel: hold, then load 4 directly
        step(1);
        en = 2'b10;
        step(3);
        chk("dis_hold_out", 32'(out_clk[0]), 32'd0);
        load = 2'b01; div_val[15:0] = 16'd4;
        step(1);
        load = 2'b00;
        chk("dis_load_pending", 32'(pending), 32'd0);
        step(5);
        en = 2'b11;
        step(3);
        chk("dis_resume_low", 32'(out_clk[0]), 32'd0);
        step(1);
        chk("dis_resume_rise", 32'(out_clk[0]), 32'd1);
        chk("ch1_at_1527", 32'(out_clk[1]), 32'(ch1_exp()));

        // Pause mid-count resumes from the held count (cnt=2 of 4)
        step(2);
        en = 2'b10;
        step(5);
        chk("pause_hold", 32'(out_clk[0]), 32'd1);
        en = 2'b11;
        step(1);
        chk("pause_resume_mid", 32'(out_clk[0]), 32'd1);
        step(1);
        chk("pause_resume_fall", 32'(out_clk[0]), 32'd0);

        // Asynchronous reset while a divisor is pending
        load = 2'b01; div_val[15:0] = 16'd9;
        step(1);
        load = 2'b00;
        chk("pre_rst_pending", 32'(pending), 32'b01);
        chk("pre_rst_ch1", 32'(out_clk[1]), 32'd1);
        #2; rst = 1'b1; #1;
        chk("async_rst_out", 32'(out_clk), 32'd0);
        chk("async_rst_pending", 32'(pending), 32'd0);
        @(posedge in_clk); #1;
        rst = 1'b0; cyc = 0;
        step(499);
        chk("post_rst_low", 32'(out_clk), 32'd0);
        step(1);
        chk("post_rst_rise", 32'(out_clk), 32'b11);
        step(9);
        chk("post_rst_no_stale", 32'(out_clk), 32'b11);

        // Divisor 0 behaves as 1
        load = 2'b01; div_val[15:0] = 16'd0;
        step(1);
        load = 2'b00;
        chk("div0_pending", 32'(pending), 32'b01);
        step(489);
        chk("div0_wait_out", 32'(out_clk[0]), 32'd1);
        step(1);
        chk("div0_apply", 32'(out_clk[0]), 32'd0);
        chk("div0_apply_pend", 32'(pending), 32'd0);
        step(1);
        chk("div0_rise", 32'(out_clk[0]), 32'd1);
        chk("div0_tick", 32'(tick), {31'd0, t_on});
        step(1);
        chk("div0_fall", 32'(out_clk[0]), 32'd0);
        chk("div0_tick_clear", 32'(tick), 32'd0);
        chk("ch1_at_1002", 32'(out_clk[1]), 32'(ch1_exp()));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
